fft_frame_feeder: RTL and testbench
===================================

# fft_frame_feeder

Frame-to-FFT transmitter for the MFCC pipeline. It buffers the incoming PCM sample stream in a ring buffer and cuts overlapping frames of `FRAME_SIZE` samples spaced `HOP` apart. Each frame is streamed into the FFT's sample-load port as `NFFT` natural-order writes, zero-padded past `FRAME_SIZE`. It then pulses the FFT start strobe and holds off the next frame until the FFT reports done.

## Interface
- `NFFT`, 512: FFT length; number of writes per frame.
- `INPUT_WIDTH`, 16: sample width, two's complement.
- `FRAME_SIZE`, 306: real samples per frame; constraint `FRAME_SIZE <= NFFT`.
- `HOP`, 153: frame advance in samples; constraint `1 <= HOP <= FRAME_SIZE`.
- `RING_DEPTH`, 512: ring buffer entries; power of two, constraint `RING_DEPTH >= FRAME_SIZE`.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `sample_valid_i`, in, 1: input sample strobe.
- `sample_i`, in, `INPUT_WIDTH`: input PCM sample.
- `sample_ready_o`, out, 1: ring can accept a sample; combinational, equal to `count != RING_DEPTH`.
- `in_valid_o`, out, 1: FFT sample write strobe.
- `frame_ptr_o`, out, `$clog2(NFFT)`: FFT write index.
- `real_out_o`, out, `INPUT_WIDTH`: FFT write data.
- `start_o`, out, 1: one-cycle FFT start pulse.
- `fft_done_i`, in, 1: FFT completion pulse.
- `busy_o`, out, 1: high in any state other than IDLE.

## Operation
- Internal registers:
  - `wr_ptr`: ring write address, `$clog2(RING_DEPTH)` bits, wraps modulo `RING_DEPTH`.
  - `base`: ring address of the current frame's first sample, same width, wraps.
  - `count`: unconsumed samples from `base` to `wr_ptr`, `$clog2(RING_DEPTH)+1` bits.
  - `idx`: send counter, `$clog2(NFFT)+1` bits.
- Sample accept: on a cycle with `sample_valid_i && sample_ready_o`, write `ring[wr_ptr]`, increment `wr_ptr`, and increment `count`. Samples offered while the ring is full are dropped; the upstream block must honour `sample_ready_o`.
- Accepting samples is independent of the FSM and continues in every state.
- States:
  - IDLE: when `count >= FRAME_SIZE`, clear `idx` and go to SEND.
  - SEND: each cycle, issue a ring read at `base + idx` (mod `RING_DEPTH`) and increment `idx`. When `idx == NFFT-1` has been issued, go to START.
  - START: assert `start_o` for exactly one cycle, then go to WAIT.
  - WAIT: on `fft_done_i`, set `base <= base + HOP`, set `count <= count - HOP` (plus 1 if a sample is accepted the same cycle), and go to IDLE.
- Data path:
  - The ring read is synchronous, one-cycle latency.
  - The output stage registers `in_valid_o`, `frame_ptr_o` (the low bits of `idx`) and a zero-pad flag (`idx >= FRAME_SIZE`).
  - `real_out_o` is forced to 0 when the zero-pad flag is set; otherwise it is the ring read data.
  - Every index 0..NFFT-1 is written, so the previous frame's padding is always overwritten.
  - The FFT performs bit-reversal placement itself; the feeder sends natural order only.
- `fft_done_i` outside WAIT is ignored.
- `count` never goes negative: WAIT is only reached with `count >= FRAME_SIZE >= HOP`.

## Timing
- Reset values:
  - `in_valid_o`, `frame_ptr_o`, `real_out_o`, `start_o` and `busy_o` are 0.
  - `wr_ptr`, `base` and `count` are 0; state is IDLE.
  - `sample_ready_o` is 1.
- IDLE→SEND: one cycle after the cycle in which `count` first reaches `FRAME_SIZE`.
- First `in_valid_o` appears one cycle after entering SEND.
- `in_valid_o` then stays high for exactly `NFFT` consecutive cycles, with `frame_ptr_o` running 0..NFFT-1.
- `start_o` rises in the cycle immediately after the `frame_ptr_o == NFFT-1` write, is high for 1 cycle, and never overlaps `in_valid_o`.
- Between frames, with data available, the gap from `fft_done_i` to the next first write is 3 cycles: WAIT→IDLE, IDLE→SEND, read latency.
- Reset asserted mid-frame: on the next edge all outputs are 0 and the ring contents are discarded (`count = 0`). No partial frame is resumed.

## Structure
- A shared package `mfcc_params_pkg` holds:
  - default constants for `NFFT`, `FRAME_SIZE`, `HOP` and `INPUT_WIDTH`, shared with the FFT and downstream blocks;
  - the `feeder_state_t` enum (IDLE, SEND, START, WAIT).
- One sub-module, `sample_ring_ram`: `RING_DEPTH` x `INPUT_WIDTH`, one write port and one synchronous read port, inferable as block RAM, with no reset on the array.

## Test plan
- Reset, then 306 samples with values 1..306 → 512 writes with `frame_ptr_o` 0..511, `real_out_o = ptr+1` for ptr<306 and 0 for ptr≥306; a single `start_o` on the cycle after ptr 511.
- After `fft_done_i`, push 153 more samples (307..459) → second frame with `real_out_o` 154 at ptr 0 and 459 at ptr 305, zeros through ptr 511.
- Withhold `fft_done_i` and push 700 samples → `sample_ready_o` falls after 512 accepted. After done, `count` = 359 and `sample_ready_o` is high again.
- Sample accepted in the same cycle as `fft_done_i` → `count` = old − 153 + 1; no sample is lost or duplicated in the next frame.
- `fft_done_i` pulsed during SEND and during IDLE → ignored: no `base` advance and no extra `start_o`.
- `rst` asserted at `frame_ptr_o == 100` → next cycle all outputs are 0 and `busy_o` is 0; no `start_o` follows until 306 fresh samples arrive.

Source files
------------

// File: rtl/mfcc_params_pkg.sv
// mfcc_params_pkg: shared MFCC frame/FFT constants and the feeder FSM state type
package mfcc_params_pkg;
  localparam int MFCC_NFFT = 512;
  localparam int MFCC_INPUT_WIDTH = 16;
  localparam int MFCC_FRAME_SIZE = 306;
  localparam int MFCC_HOP = 153;
  localparam int MFCC_RING_DEPTH = 512;
  typedef enum logic [1:0] {IDLE, SEND, START, WAIT} feeder_state_t;
endpackage

// File: rtl/fft_frame_feeder_if.sv
// fft_frame_feeder_if: PCM sample input (valid/ready/data) and FFT load port (in_valid/frame_ptr/real_out, start/done, busy)
interface fft_frame_feeder_if #(
  parameter int INPUT_WIDTH = 16,
  parameter int NFFT = 512
);
  logic sample_valid_i;
  logic [INPUT_WIDTH-1:0] sample_i;
  logic sample_ready_o;
  logic in_valid_o;
  logic [$clog2(NFFT)-1:0] frame_ptr_o;
  logic [INPUT_WIDTH-1:0] real_out_o;
  logic start_o;
  logic fft_done_i;
  logic busy_o;
  modport slave (
    input sample_valid_i, sample_i, fft_done_i,
    output sample_ready_o, in_valid_o, frame_ptr_o, real_out_o, start_o, busy_o
  );
  modport master (
    output sample_valid_i, sample_i, fft_done_i,
    input sample_ready_o, in_valid_o, frame_ptr_o, real_out_o, start_o, busy_o
  );
endinterface

// File: rtl/sample_ring_ram.sv
// sample_ring_ram: DEPTH x WIDTH block RAM, one write port (i_we/i_waddr/i_wdata) and one registered read port (i_raddr -> o_rdata)
module sample_ring_ram #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/fft_frame_feeder.sv
// fft_frame_feeder: ring-buffers PCM samples (clk, rst, bus.sample_*) and streams overlapping zero-padded frames into the FFT load port (bus.in_valid/frame_ptr/real_out, start/done, busy)
module fft_frame_feeder
  import mfcc_params_pkg::*;
#(
  parameter int NFFT = MFCC_NFFT,
  parameter int INPUT_WIDTH = MFCC_INPUT_WIDTH,
  parameter int FRAME_SIZE = MFCC_FRAME_SIZE,
  parameter int HOP = MFCC_HOP,
  parameter int RING_DEPTH = MFCC_RING_DEPTH
) (
  input logic clk,
  input logic rst,
  fft_frame_feeder_if.slave bus
);
  localparam int AW = $clog2(RING_DEPTH);
  localparam int PW = $clog2(NFFT);
  feeder_state_t r_state, w_state_nxt;
  logic [AW-1:0] r_wr_ptr, r_base, w_rd_addr;
  logic [AW:0] r_count;
  logic [PW:0] r_idx;
  logic [PW-1:0] r_ptr;
  logic r_valid, r_pad, r_start, w_ready, w_accept, w_advance;
  logic [INPUT_WIDTH-1:0] w_rd_data;
  assign w_ready = r_count != (AW+1)'(RING_DEPTH);
  assign w_accept = bus.sample_valid_i && w_ready && !rst;
  assign w_rd_addr = r_base + AW'(r_idx);
  assign bus.sample_ready_o = w_ready;
  assign bus.in_valid_o = r_valid;
  assign bus.frame_ptr_o = r_ptr;
  assign bus.real_out_o = r_valid && !r_pad ? w_rd_data : '0;
  assign bus.start_o = r_start;
  assign bus.busy_o = r_state != IDLE;
  sample_ring_ram #(.DEPTH(RING_DEPTH), .WIDTH(INPUT_WIDTH)) u_ram (
    .clk(clk),
    .i_we(w_accept),
    .i_waddr(r_wr_ptr),
    .i_wdata(bus.sample_i),
    .i_raddr(w_rd_addr),
    .o_rdata(w_rd_data)
  );
  always_comb begin
    w_state_nxt = r_state;
    w_advance = 1'b0;
    case (r_state)
      IDLE: w_state_nxt = r_count >= (AW+1)'(FRAME_SIZE) ? SEND : IDLE;
      SEND: w_state_nxt = r_idx == (PW+1)'(NFFT-1) ? START : SEND;
      START: w_state_nxt = WAIT;
      WAIT: begin
        w_state_nxt = bus.fft_done_i ? IDLE : WAIT;
        w_advance = bus.fft_done_i;
      end
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_wr_ptr <= '0;
      r_base <= '0;
      r_count <= '0;
      r_idx <= '0;
      r_ptr <= '0;
      r_valid <= 1'b0;
      r_pad <= 1'b0;
      r_start <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wr_ptr <= r_wr_ptr + AW'(w_accept);
      r_base <= w_advance ? r_base + AW'(HOP) : r_base;
      r_count <= r_count + (AW+1)'(w_accept) - (w_advance ? (AW+1)'(HOP) : '0);
      r_idx <= r_state == SEND ? r_idx + 1'b1 : '0;
      r_ptr <= r_idx[PW-1:0];
      r_valid <= r_state == SEND;
      r_pad <= r_idx >= (PW+1)'(FRAME_SIZE);
      r_start <= r_state == START;
    end
  end
endmodule

// File: tb/tb_fft_frame_feeder.sv
// tb_fft_frame_feeder: scoreboard bench for fft_frame_feeder frame cutting, padding, backpressure, done handling and reset
module tb_fft_frame_feeder;
  import mfcc_params_pkg::*;
  localparam int NFFT = MFCC_NFFT;
  localparam int W = MFCC_INPUT_WIDTH;
  localparam int FS = MFCC_FRAME_SIZE;
  localparam int HOP = MFCC_HOP;
  localparam int RD = MFCC_RING_DEPTH;
  typedef struct {bit is_start; int ptr; int data;} ev_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fft_frame_feeder_if #(.INPUT_WIDTH(W), .NFFT(NFFT)) bus ();
  fft_frame_feeder #(.NFFT(NFFT), .INPUT_WIDTH(W), .FRAME_SIZE(FS), .HOP(HOP), .RING_DEPTH(RD)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  ev_t sb[$];
  int ring_q[$];
  int total = 0;
  int bad = 0;
  int frames_exp = 0;
  int starts_seen = 0;
  int next_val = 1;
  bit model_busy = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask
  task automatic expect_frame();
    for (int p = 0; p < NFFT; p++) sb.push_back('{1'b0, p, p < FS ? ring_q[p] : 0});
    sb.push_back('{1'b1, 0, 0});
    frames_exp++;
    model_busy = 1;
  endtask
  task automatic step(bit v, bit done, bit eff);
    bit acc;
    acc = v && ring_q.size() != RD;
    bus.sample_valid_i = v;
    bus.sample_i = W'(next_val);
    bus.fft_done_i = done;
    chk("ready", bus.sample_ready_o, ring_q.size() != RD);
    if (eff) begin
      repeat (HOP) ring_q.delete(0);
      model_busy = 0;
    end
    if (acc) ring_q.push_back(next_val);
    if (v) next_val++;
    if (!model_busy && ring_q.size() >= FS) expect_frame();
    @(negedge clk);
    bus.sample_valid_i = 1'b0;
    bus.fft_done_i = 1'b0;
  endtask
  task automatic push(int n);
    for (int i = 0; i < n; i++) step(1, 0, 0);
  endtask
  task automatic do_done(bit v);
    int n = 0;
    while (starts_seen != frames_exp && n < 3000) begin
      step(0, 0, 0);
      n++;
    end
    chk("start_arrived", starts_seen, frames_exp);
    step(v, 1, 1);
  endtask
  task automatic wait_valid(int ptr);
    int n = 0;
    while (!(bus.in_valid_o && bus.frame_ptr_o == ptr) && n < 2000) begin
      step(0, 0, 0);
      n++;
    end
    chk("reach_ptr", bus.in_valid_o && bus.frame_ptr_o == ptr, 1);
  endtask
  bit prev_valid = 0;
  int prev_ptr = 0;
  always @(negedge clk) begin
    ev_t e;
    if (rst) prev_valid = 0;
    else begin
      if (bus.in_valid_o || bus.start_o) begin
        chk("no_overlap", bus.in_valid_o && bus.start_o, 0);
        if (sb.size() == 0) chk("unexpected_output", {bus.in_valid_o, bus.start_o}, 0);
        else begin
          e = sb.pop_front();
          chk("kind", bus.start_o, e.is_start);
          if (e.is_start) begin
            chk("start_after_last", prev_valid && prev_ptr == NFFT-1, 1);
            starts_seen++;
          end else begin
            chk("ptr", bus.frame_ptr_o, e.ptr);
            chk("data", bus.real_out_o, e.data);
            chk("contig", e.ptr == 0 ? prev_valid : (prev_valid && prev_ptr == e.ptr-1), e.ptr != 0);
          end
        end
      end
      prev_valid = bus.in_valid_o;
      prev_ptr = bus.frame_ptr_o;
    end
  end
  initial begin
    int g;
    bus.sample_valid_i = 1'b0;
    bus.sample_i = '0;
    bus.fft_done_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_valid", bus.in_valid_o, 0);
    chk("rst_ptr", bus.frame_ptr_o, 0);
    chk("rst_real", bus.real_out_o, 0);
    chk("rst_start", bus.start_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_ready", bus.sample_ready_o, 1);
    rst = 1'b0;
    push(FS);
    chk("busy_still_idle", bus.busy_o, 0);
    step(0, 0, 0);
    chk("busy_send", bus.busy_o, 1);
    do_done(0);
    step(0, 1, 0);
    push(HOP);
    wait_valid(5);
    step(0, 1, 0);
    do_done(0);
    push(700);
    chk("ready_full", bus.sample_ready_o, 0);
    do_done(0);
    chk("ready_after_done", bus.sample_ready_o, 1);
    g = 1;
    while (!bus.in_valid_o && g < 10) begin
      step(0, 0, 0);
      g++;
    end
    chk("done_to_write_gap", g, 3);
    do_done(1);
    push(FS - (RD - HOP - HOP + 1));
    wait_valid(100);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_valid", bus.in_valid_o, 0);
    chk("mid_rst_ptr", bus.frame_ptr_o, 0);
    chk("mid_rst_real", bus.real_out_o, 0);
    chk("mid_rst_start", bus.start_o, 0);
    chk("mid_rst_busy", bus.busy_o, 0);
    sb.delete();
    ring_q.delete();
    model_busy = 0;
    frames_exp = starts_seen;
    rst = 1'b0;
    push(FS - 1);
    repeat (20) step(0, 0, 0);
    chk("no_frame_below_fs", bus.busy_o, 0);
    push(1);
    do_done(0);
    repeat (5) step(0, 0, 0);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
